// File: rtl/cook_timer.sv
// Purpose: BCD mm:ss countdown cook timer feeding timer_done to the magnetron control.
// Latency: digits and done_pulse update one cycle after the deciding edge; timer_done is a decode of the digits with no added delay.
// Backpressure: none; a load arriving while counting or carrying a non-BCD digit is dropped, and a pause holds the prescaler.
//
// Ports:
//   clk, rstn          - clock (rising edge), asynchronous active-low reset
//   clearn             - synchronous active-low clear (keypad CLEAR)
//   load_en/load_digit - one-cycle keypad strobe plus BCD digit, shifted in from the right
//   enable             - count enable (magnetron on)
//   sec_ones..min_tens - BCD display digits
//   timer_done         - level, high while the display reads 00:00
//   done_pulse         - one cycle, when the count reaches 00:00 by decrementing
module cook_timer #(
  parameter int TICK_DIV = 100,
  parameter int PW       = 7
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clearn,
  input  logic       load_en,
  input  logic [3:0] load_digit,
  input  logic       enable,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       timer_done,
  output logic       done_pulse
);

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_pulse_q, done_pulse_d;
  logic          load_ok;
  logic          tick;

  assign timer_done = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) &&
                      (min_ones_q == 4'd0) && (min_tens_q == 4'd0);

  // A load is only taken while stopped and with a legal BCD digit; a rejected
  // load behaves as if the strobe never happened, so counting carries on.
  assign load_ok = load_en && !enable && (load_digit <= 4'd9);

  always_comb begin
    sec_ones_d   = sec_ones_q;
    sec_tens_d   = sec_tens_q;
    min_ones_d   = min_ones_q;
    min_tens_d   = min_tens_q;
    pre_d        = pre_q;
    done_pulse_d = 1'b0;
    tick         = 1'b0;

    if (!clearn) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
      pre_d      = '0;
    end else if (load_ok) begin
      min_tens_d = min_ones_q;
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = load_digit;
      pre_d      = '0;
    end else if (enable && !timer_done) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    if (tick) begin
      if (sec_ones_q != 4'd0) begin
        sec_ones_d = sec_ones_q - 4'd1;
      end else if (sec_tens_q != 4'd0) begin
        sec_ones_d = 4'd9;
        sec_tens_d = sec_tens_q - 4'd1;
      end else begin
        // Seconds are 00 and the display is nonzero, so minutes must be nonzero.
        sec_ones_d = 4'd9;
        sec_tens_d = 4'd5;
        if (min_ones_q != 4'd0) begin
          min_ones_d = min_ones_q - 4'd1;
        end else begin
          min_ones_d = 4'd9;
          min_tens_d = min_tens_q - 4'd1;
        end
      end
      // Pulse lines up with the edge that makes timer_done rise.
      done_pulse_d = (sec_ones_d == 4'd0) && (sec_tens_d == 4'd0) &&
                     (min_ones_d == 4'd0) && (min_tens_d == 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sec_ones_q   <= 4'd0;
      sec_tens_q   <= 4'd0;
      min_ones_q   <= 4'd0;
      min_tens_q   <= 4'd0;
      pre_q        <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      sec_ones_q   <= sec_ones_d;
      sec_tens_q   <= sec_tens_d;
      min_ones_q   <= min_ones_d;
      min_tens_q   <= min_tens_d;
      pre_q        <= pre_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign sec_ones   = sec_ones_q;
  assign sec_tens   = sec_tens_q;
  assign min_ones   = min_ones_q;
  assign min_tens   = min_tens_q;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_cook_timer.sv
module tb_cook_timer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clearn;
  logic       load_en;
  logic [3:0] load_digit;
  logic       enable;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       timer_done, done_pulse;
  logic [15:0] disp;

  int checks = 0;
  int errors = 0;

  cook_timer #(.TICK_DIV(4), .PW(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clearn     (clearn),
    .load_en    (load_en),
    .load_digit (load_digit),
    .enable     (enable),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .timer_done (timer_done),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    load_en = 1'b1;
    load_digit = d;
    step(1);
    load_en = 1'b0;
  endtask

  task automatic do_clear();
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; clearn = 1'b1; load_en = 1'b0; load_digit = 4'd0; enable = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: disp=%h done=%b pulse=%b, want 0000 1 0", disp, timer_done, done_pulse);
    end
    key(4'd1); key(4'd0);
    enable = 1'b1;
    step(6);
    checks++;
    if (disp !== 16'h0009) begin
      errors++;
      $display("FAIL reset_precount: disp=%h want 0009", disp);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: disp=%h done=%b pulse=%b, want 0000 1 0", disp, timer_done, done_pulse);
    end
    enable = 1'b0;
    step(1);
    rstn = 1'b1;
    step(1);
  endtask

  task automatic test_countdown();
    int pulses;
    int pulse_at;
    pulses = 0; pulse_at = -1;
    key(4'd1); key(4'd0);
    checks++;
    if (disp !== 16'h0010 || timer_done !== 1'b0) begin
      errors++;
      $display("FAIL load_10: disp=%h done=%b, want 0010 0", disp, timer_done);
    end
    enable = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      step(1);
      if (done_pulse === 1'b1) begin
        pulses++;
        pulse_at = c;
      end
      if (c == 3) begin
        checks++;
        if (disp !== 16'h0010) begin
          errors++;
          $display("FAIL cd_before_tick: disp=%h want 0010", disp);
        end
      end
      if (c == 4) begin
        checks++;
        if (disp !== 16'h0009) begin
          errors++;
          $display("FAIL cd_first_tick: disp=%h want 0009", disp);
        end
      end
      if (c == 39) begin
        checks++;
        if (disp !== 16'h0001 || timer_done !== 1'b0) begin
          errors++;
          $display("FAIL cd_last_sec: disp=%h done=%b want 0001 0", disp, timer_done);
        end
      end
      if (c == 40) begin
        checks++;
        if (disp !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b1) begin
          errors++;
          $display("FAIL cd_zero: disp=%h done=%b pulse=%b want 0000 1 1", disp, timer_done, done_pulse);
        end
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != 40) begin
      errors++;
      $display("FAIL cd_pulse_count: pulses=%0d at=%0d want 1 at 40", pulses, pulse_at);
    end
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1) begin
      errors++;
      $display("FAIL cd_hold_zero: disp=%h done=%b want 0000 1", disp, timer_done);
    end
    enable = 1'b0;
  endtask

  task automatic test_borrow();
    do_clear();
    key(4'd1); key(4'd0); key(4'd0);
    enable = 1'b1;
    step(4);
    checks++;
    if (disp !== 16'h0059) begin
      errors++;
      $display("FAIL borrow_min: disp=%h want 0059", disp);
    end
    step(4);
    checks++;
    if (disp !== 16'h0058) begin
      errors++;
      $display("FAIL borrow_next: disp=%h want 0058", disp);
    end
    enable = 1'b0;
    do_clear();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    enable = 1'b1;
    step(4);
    checks++;
    if (disp !== 16'h0959) begin
      errors++;
      $display("FAIL borrow_tens_min: disp=%h want 0959", disp);
    end
    enable = 1'b0;
  endtask

  task automatic test_pause();
    do_clear();
    key(4'd0); key(4'd5);
    enable = 1'b1;
    step(2);
    enable = 1'b0;
    step(20);
    checks++;
    if (disp !== 16'h0005) begin
      errors++;
      $display("FAIL pause_hold: disp=%h want 0005", disp);
    end
    enable = 1'b1;
    step(1);
    checks++;
    if (disp !== 16'h0005) begin
      errors++;
      $display("FAIL pause_resume1: disp=%h want 0005", disp);
    end
    step(1);
    checks++;
    if (disp !== 16'h0004) begin
      errors++;
      $display("FAIL pause_resume2: disp=%h want 0004", disp);
    end
  endtask

  task automatic test_ignored();
    // Prescaler is 0 here, so this cycle cannot tick.
    key(4'd7);
    checks++;
    if (disp !== 16'h0004) begin
      errors++;
      $display("FAIL load_while_run: disp=%h want 0004", disp);
    end
    enable = 1'b0;
    key(4'hA);
    checks++;
    if (disp !== 16'h0004) begin
      errors++;
      $display("FAIL load_non_bcd: disp=%h want 0004", disp);
    end
    do_clear();
    key(4'd0); key(4'd7);
    enable = 1'b1;
    step(2);
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clear_run: disp=%h done=%b pulse=%b want 0000 1 0", disp, timer_done, done_pulse);
    end
    step(1);
    checks++;
    if (done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_pulse: pulse=%b want 0", done_pulse);
    end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    checks++;
    if (disp !== 16'h2345) begin
      errors++;
      $display("FAIL shift_overflow: disp=%h want 2345", disp);
    end
    clearn = 1'b0; load_en = 1'b1; load_digit = 4'd6;
    step(1);
    clearn = 1'b1; load_en = 1'b0;
    checks++;
    if (disp !== 16'h0000) begin
      errors++;
      $display("FAIL clear_over_load: disp=%h want 0000", disp);
    end
    key(4'd0);
    checks++;
    if (disp !== 16'h0000 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL load_zero_pulse: disp=%h pulse=%b want 0000 0", disp, done_pulse);
    end
    key(4'd9); key(4'd0);
    checks++;
    if (disp !== 16'h0090) begin
      errors++;
      $display("FAIL load_90: disp=%h want 0090", disp);
    end
    enable = 1'b1;
    step(4);
    checks++;
    if (disp !== 16'h0089) begin
      errors++;
      $display("FAIL cnt90_first: disp=%h want 0089", disp);
    end
    step(355);
    checks++;
    if (disp !== 16'h0001 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL cnt90_last: disp=%h pulse=%b want 0001 0", disp, done_pulse);
    end
    step(1);
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b1) begin
      errors++;
      $display("FAIL cnt90_zero: disp=%h done=%b pulse=%b want 0000 1 1", disp, timer_done, done_pulse);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
